hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter FWD_EN, default 1: 1 = forwarding enabled; 0 = every RAW hazard resolved by stalling.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 SHALL have port R, input, 1: reset, synchronous and active-low, sampled on clk rising edge.
REQ-004 SHALL have port ID_Rn, input, 4: ID-stage first source register.
REQ-005 SHALL have port ID_Rm, input, 4: ID-stage second source register.
REQ-006 SHALL have port ID_Rd, input, 4: ID-stage destination register, also the store-data source.
REQ-007 SHALL have port ID_use_Rn / ID_use_Rm / ID_use_Rd, input, 1 each: the corresponding field is read as a source.
REQ-008 SHALL have port ID_RF_enable, input, 1: the ID instruction writes ID_Rd.
REQ-009 SHALL have port ID_load_instr, input, 1: the ID instruction is a load.
REQ-010 SHALL have port branch_taken, input, 1: a B or BL is resolved taken this cycle.
REQ-011 SHALL have port PC_LE, output, 1: PC load enable.
REQ-012 SHALL have port IFID_LE, output, 1: IF_ID load enable.
REQ-013 SHALL have port SS, output, 1: 1 = CU mux drives NOP (all control signals 0) into ID_EX.
REQ-014 SHALL have port IFID_flush, output, 1: IF_ID loads a NOP on the next edge.
REQ-015 SHALL have ports FWD_A, FWD_B, FWD_D, output, 2 each: operand source for Rn, Rm and Rd. 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.

Function
REQ-016 SHALL hold a shadow pipeline of three slots (EX, MEM, WB), each storing rd[3:0], rf (write enable) and ld (load; EX slot only).
REQ-017 SHALL, on each clk edge with R=1, shift MEM to WB and EX to MEM.
REQ-018 SHALL, on that same edge, load EX from {ID_Rd, ID_RF_enable, ID_load_instr}, or with rf=0 and ld=0 when SS=1.
REQ-019 SHALL define a source as matching a slot when: use bit = 1, slot rf = 1, slot rd = source register, and source register != 15.
REQ-020 SHALL, with FWD_EN=1, compute each FWD_x combinationally with priority EX (01) > MEM (10) > WB (11) > register file (00).
REQ-021 SHALL assert a load-use stall when any used source matches the EX slot and the EX slot has ld=1.
REQ-022 SHALL, with FWD_EN=0, assert a stall when any used source matches any slot, and drive every FWD_x to 00.
REQ-023 SHALL, during a stall, drive PC_LE=0, IFID_LE=0, SS=1 and IFID_flush=0 in the same cycle.
REQ-024 SHALL, when not stalling, drive PC_LE=1, IFID_LE=1 and SS=0.
REQ-025 SHALL limit a load-use stall to exactly 1 cycle; on the next cycle the load is in MEM and is forwarded with 10.
REQ-026 SHALL, with FWD_EN=0, keep stalling until no slot matches; the maximum is 3 consecutive cycles.
REQ-027 SHALL drive IFID_flush=1 for one cycle when branch_taken=1 and there is no stall; PC_LE and IFID_LE remain 1.
REQ-028 SHALL give priority to the stall when a stall and branch_taken occur in the same cycle; the branch is ignored that cycle and is re-presented by ID.
REQ-029 SHALL never flush or stall on register 15 matches.
REQ-030 SHALL keep all outputs glitch-free functions of the registered slots and the current ID inputs, with no added latency.

Reset
REQ-031 SHALL, on a clk edge with R=0, clear all slots: rd=0, rf=0, ld=0.
REQ-032 SHALL, while R=0, force PC_LE=1, IFID_LE=1, SS=1, IFID_flush=0 and FWD_A=FWD_B=FWD_D=00.
REQ-033 SHALL, when R is asserted mid-stall or mid-flush, abort that stall or flush; the first cycle after R=1 sees empty slots and no hazard.

Verification
REQ-034 SHALL cover EX forwarding: ADD R1 (rf=1), then SUB using Rn=R1 -> next cycle FWD_A=01, no stall.
REQ-035 SHALL cover load-use: LDR R2, then ADD using Rm=R2 -> one cycle with PC_LE=0, IFID_LE=0, SS=1; next cycle FWD_B=10, SS=0.
REQ-036 SHALL cover the priority chain: writes to R3 in the WB, MEM and EX slots with Rn=R3 -> FWD_A=01; once only the WB slot holds R3 -> FWD_A=11.
REQ-037 SHALL cover a simultaneous load-use stall and branch_taken=1 -> IFID_flush=0, SS=1; with branch_taken still 1 next cycle -> IFID_flush=1.
REQ-038 SHALL cover FWD_EN=0: ADD R4, then a use of R4 -> 3 stall cycles, then PC_LE=1 with FWD_A=00.
REQ-039 SHALL cover reset: R=0 during a load-use stall -> PC_LE=1, SS=1, FWD=00; after R=1 with the same ID inputs -> no stall.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks the EX/MEM/WB destinations of in-flight instructions and
// derives operand forwarding selects, load-use (or no-forwarding) stalls and branch flushes.
module hazard_unit #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       R,
  input  logic [3:0] ID_Rn,
  input  logic [3:0] ID_Rm,
  input  logic [3:0] ID_Rd,
  input  logic       ID_use_Rn,
  input  logic       ID_use_Rm,
  input  logic       ID_use_Rd,
  input  logic       ID_RF_enable,
  input  logic       ID_load_instr,
  input  logic       branch_taken,
  output logic       PC_LE,
  output logic       IFID_LE,
  output logic       SS,
  output logic       IFID_flush,
  output logic [1:0] FWD_A,
  output logic [1:0] FWD_B,
  output logic [1:0] FWD_D
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic [3:0] ex_rd_r, mem_rd_r, wb_rd_r;
  logic       ex_rf_r, mem_rf_r, wb_rf_r;
  logic       ex_ld_r;

  logic       a_ex_s, a_mem_s, a_wb_s;
  logic       b_ex_s, b_mem_s, b_wb_s;
  logic       d_ex_s, d_mem_s, d_wb_s;
  logic       any_ex_s, any_slot_s;
  logic       stall_s;
  logic [1:0] fwd_a_s, fwd_b_s, fwd_d_s;

  // R15 is the PC and is never produced by an in-flight instruction, so it never matches.
  function automatic logic src_match(input logic       use_bit,
                                     input logic [3:0] src,
                                     input logic       slot_rf,
                                     input logic [3:0] slot_rd);
    return use_bit && slot_rf && (slot_rd == src) && (src != 4'd15);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
    logic [1:0] sel;
    if (m_ex) begin
      sel = SEL_EX;
    end else if (m_mem) begin
      sel = SEL_MEM;
    end else if (m_wb) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  assign a_ex_s  = src_match(ID_use_Rn, ID_Rn, ex_rf_r,  ex_rd_r);
  assign a_mem_s = src_match(ID_use_Rn, ID_Rn, mem_rf_r, mem_rd_r);
  assign a_wb_s  = src_match(ID_use_Rn, ID_Rn, wb_rf_r,  wb_rd_r);
  assign b_ex_s  = src_match(ID_use_Rm, ID_Rm, ex_rf_r,  ex_rd_r);
  assign b_mem_s = src_match(ID_use_Rm, ID_Rm, mem_rf_r, mem_rd_r);
  assign b_wb_s  = src_match(ID_use_Rm, ID_Rm, wb_rf_r,  wb_rd_r);
  assign d_ex_s  = src_match(ID_use_Rd, ID_Rd, ex_rf_r,  ex_rd_r);
  assign d_mem_s = src_match(ID_use_Rd, ID_Rd, mem_rf_r, mem_rd_r);
  assign d_wb_s  = src_match(ID_use_Rd, ID_Rd, wb_rf_r,  wb_rd_r);

  assign any_ex_s   = a_ex_s | b_ex_s | d_ex_s;
  assign any_slot_s = any_ex_s | a_mem_s | b_mem_s | d_mem_s | a_wb_s | b_wb_s | d_wb_s;

  // Stall decision and forwarding selects, independent of reset forcing.
  always_comb begin
    fwd_a_s = SEL_RF;
    fwd_b_s = SEL_RF;
    fwd_d_s = SEL_RF;
    if (FWD_EN) begin
      stall_s = any_ex_s & ex_ld_r;
      fwd_a_s = fwd_sel(a_ex_s, a_mem_s, a_wb_s);
      fwd_b_s = fwd_sel(b_ex_s, b_mem_s, b_wb_s);
      fwd_d_s = fwd_sel(d_ex_s, d_mem_s, d_wb_s);
    end else begin
      stall_s = any_slot_s;
    end
  end

  // Pipeline control outputs; reset forces a bubble with fetch enabled.
  always_comb begin
    PC_LE      = 1'b1;
    IFID_LE    = 1'b1;
    SS         = 1'b0;
    IFID_flush = 1'b0;
    FWD_A      = SEL_RF;
    FWD_B      = SEL_RF;
    FWD_D      = SEL_RF;
    if (!R) begin
      SS = 1'b1;
    end else if (stall_s) begin
      PC_LE   = 1'b0;
      IFID_LE = 1'b0;
      SS      = 1'b1;
      FWD_A   = fwd_a_s;
      FWD_B   = fwd_b_s;
      FWD_D   = fwd_d_s;
    end else begin
      IFID_flush = branch_taken;
      FWD_A      = fwd_a_s;
      FWD_B      = fwd_b_s;
      FWD_D      = fwd_d_s;
    end
  end

  // Shadow pipeline: shift EX->MEM->WB, inserting a bubble into EX on a stall.
  always_ff @(posedge clk) begin
    if (!R) begin
      ex_rd_r  <= 4'd0;
      ex_rf_r  <= 1'b0;
      ex_ld_r  <= 1'b0;
      mem_rd_r <= 4'd0;
      mem_rf_r <= 1'b0;
      wb_rd_r  <= 4'd0;
      wb_rf_r  <= 1'b0;
    end else begin
      wb_rd_r  <= mem_rd_r;
      wb_rf_r  <= mem_rf_r;
      mem_rd_r <= ex_rd_r;
      mem_rf_r <= ex_rf_r;
      ex_rd_r  <= ID_Rd;
      if (stall_s) begin
        ex_rf_r <= 1'b0;
        ex_ld_r <= 1'b0;
      end else begin
        ex_rf_r <= ID_RF_enable;
        ex_ld_r <= ID_load_instr;
      end
    end
  end

endmodule
